mux_port_arbiter: RTL and testbench
===================================

Name: mux_port_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource among NREQ requesters. Example resources: a memory port, or a register-file write port fed through the N-bit wide-fan-in mux tree.
- Produces a one-hot grant vector and a registered binary select. The select drives the mux tree's S input directly.
- Grants one owner at a time, with a bounded hold time and a guaranteed break-before-make turnaround cycle.

Parameters:
- NREQ, 4, number of requesters; legal 2..64 (64 matches the widest mux in the library).
- SELW, 6, width of sel; must satisfy 2**SELW >= NREQ.
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; legal 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  request per requester; held high until granted and finished.
- done  input  NREQ  one-cycle release strobe from the current owner.
- grant  output  NREQ  one-hot grant, registered; all-zero when no owner.
- sel  output  SELW  binary index of current/last owner, registered; drives mux S.
- busy  output  1  high while any grant bit is high.
- timeout  output  1  one-cycle pulse when an owner is force-released by the hold limit.

Behaviour:
- Reset: asynchronous on rst_n low. Values:
  - grant=0, sel=0, busy=0, timeout=0
  - priority pointer ptr=0, hold counter=0
  - state=IDLE
- State IDLE:
  - Each cycle, search req starting at index ptr, wrapping modulo NREQ; the first set bit wins.
  - If a winner k exists, the next edge sets grant=1<<k, sel=k, busy=1, hold counter=1, state=GRANT. Latency is 1 cycle from req sampled to grant visible.
  - If no req is set: stay in IDLE; grant stays 0; sel holds its last value so the mux output stays stable.
- State GRANT (owner k):
  - Release conditions, evaluated at each edge, in priority order:
    - (a) done[k]=1
    - (b) req[k]=0 (requester withdrew)
    - (c) hold counter == MAX_HOLD
  - On any release: next edge sets grant=0, busy=0, ptr=(k+1) mod NREQ, state=IDLE.
  - Timeout pulse: if release is due to (c) only, timeout=1 for that one cycle. It clears on the following edge regardless of state.
  - Otherwise: hold counter increments; grant and sel are unchanged.
- Break-before-make: every release is followed by at least one cycle with grant=0. A requester may be re-granted no earlier than 2 cycles after its grant drops.
- Ignored inputs: done bits from non-owners, and done while in IDLE.
- Fairness: the pointer always advances past the last owner, including after timeout, so every continuously asserted req is granted within NREQ arbitration rounds.
- Simultaneous events:
  - done[k] and hold limit in the same cycle: treated as a normal release; timeout stays 0.
  - New requests arriving during GRANT are evaluated only in IDLE.
- Reset mid-grant: all outputs clear asynchronously and the pointer returns to 0. No timeout pulse is generated.
- Invariants, all checkable by assertion:
  - grant is one-hot or zero.
  - sel equals the grant index whenever busy=1.
  - busy equals the OR-reduction of grant.

Test Plan:
- Reset, single requester: rst_n low then high; req=0010 at cycle 0. Expect grant=0010, sel=1, busy=1 at cycle 1. Pulse done[1] at cycle 3; expect grant=0000 at cycle 4 and sel still 1.
- Round-robin: hold req=1111 continuously; each owner pulses done on its 2nd grant cycle. Expect grant order 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between each.
- Timeout: MAX_HOLD=4; req=0100 held, never done. Expect grant=0100 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle. Expect re-grant 2 cycles later, and timeout never high in any other cycle.
- Withdraw and tie: owner drops req mid-grant, expect release with timeout=0. Separately, done coinciding with the hold limit, expect timeout=0.
- Async reset mid-grant: assert rst_n low between edges while grant=1000. Expect grant, busy and sel at 0 immediately. After release with req=1001, expect index 0 granted first.
- Non-owner done: while 0001 is owner, pulse done[2]. Expect no change to grant and no hold-counter reset.

Source files
------------

// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter
//   Round-robin arbiter sharing one datapath resource (memory port, register-file
//   write port behind a wide mux tree) among NREQ requesters. One owner at a time,
//   bounded hold time, and at least one idle cycle between owners.
//
// Parameters
//   NREQ     : number of requesters (2..64)
//   SELW     : width of sel, 2**SELW >= NREQ
//   MAX_HOLD : maximum consecutive grant cycles per owner (1..255)
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : per-requester request, held until granted and finished
//   done    : one-cycle release strobe from the current owner
//   grant   : registered one-hot grant, zero when no owner
//   sel     : registered binary index of current/last owner, drives mux S
//   busy    : high while any grant bit is high
//   timeout : one-cycle pulse when the owner is force-released by the hold limit

module mux_port_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned SELW     = 6,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] done,
   output logic [NREQ-1:0] grant,
   output logic [SELW-1:0] sel,
   output logic            busy,
   output logic            timeout
);

   // Wide enough for MAX_HOLD up to 255.
   localparam int unsigned HoldW = 8;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   // -------------------------------------------------------------------------
   // Round-robin search: rotate req so that index ptr lands at bit 0, take the
   // first set bit, then map the rotated position back to a requester index.
   // -------------------------------------------------------------------------
   logic [NREQ-1:0] req_rot;
   logic            found;
   logic [SELW-1:0] win_idx;
   int unsigned     cand;

   always_comb begin
      req_rot = NREQ'({req, req} >> ptr_q);
      found   = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!found && req_rot[j]) begin
            found = 1'b1;
            cand  = int'(ptr_q) + j;
            if (cand >= NREQ) begin
               cand = cand - NREQ;
            end
            win_idx = SELW'(cand);
         end
      end
   end

   // Owner-qualified inputs; masking with the one-hot grant ignores every
   // non-owner done bit and avoids indexing by sel.
   logic own_done;
   logic own_req;
   logic hold_max;

   assign own_done = |(done & grant_q);
   assign own_req  = |(req & grant_q);
   assign hold_max = (hold_q == HoldW'(MAX_HOLD));

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         StIdle: begin
            // sel keeps the last owner so the mux output stays stable.
            if (found) begin
               state_d = StGrant;
               grant_d = NREQ'(1) << win_idx;
               sel_d   = win_idx;
               busy_d  = 1'b1;
               hold_d  = HoldW'(1);
            end
         end

         StGrant: begin
            if (own_done || !own_req || hold_max) begin
               state_d = StIdle;
               grant_d = '0;
               busy_d  = 1'b0;
               hold_d  = '0;
               ptr_d   = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
               // Pulse only when the hold limit is the sole reason to release.
               timeout_d = own_req && !own_done;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
            grant_d = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         sel_q     <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant   = grant_q;
   assign sel     = sel_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

   // -------------------------------------------------------------------------
   // Invariants
   // -------------------------------------------------------------------------
   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant_q));
   a_busy_is_or : assert property (@(posedge clk) disable iff (!rst_n)
      busy_q == (|grant_q));
   a_sel_matches : assert property (@(posedge clk) disable iff (!rst_n)
      busy_q |-> (grant_q == (NREQ'(1) << sel_q)));

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Self-checking bench for mux_port_arbiter (NREQ=4, SELW=6, MAX_HOLD=4).
// A cycle-level reference model tracks owner, pointer and hold count as plain
// integers and is stepped at every clock edge alongside the DUT.

module tb_mux_port_arbiter;

   localparam int unsigned NREQ     = 4;
   localparam int unsigned SELW     = 6;
   localparam int unsigned MAX_HOLD = 4;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [NREQ-1:0] req   = '0;
   logic [NREQ-1:0] done  = '0;
   logic [NREQ-1:0] grant;
   logic [SELW-1:0] sel;
   logic            busy;
   logic            timeout;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_owner;   // -1 when nobody holds the grant
   int m_ptr;
   int m_hold;
   int m_sel;
   bit m_to;

   always #5 clk = ~clk;

   mux_port_arbiter #(
      .NREQ     (NREQ),
      .SELW     (SELW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   wire [11:0] obs = {grant, sel, busy, timeout};

   function automatic logic [11:0] model_vec();
      logic [NREQ-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return {g, SELW'(m_sel), (m_owner >= 0), m_to};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_sel   = 0;
      m_to    = 1'b0;
   endtask

   // One clock edge of the arbitration rules, using the current req/done.
   task automatic model_edge();
      bit rel;
      m_to = 1'b0;
      if (m_owner < 0) begin
         for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (m_ptr + i) % NREQ;
            if (m_owner < 0 && req[c]) begin
               m_owner = c;
               m_sel   = c;
               m_hold  = 1;
            end
         end
      end else begin
         rel = 1'b0;
         if (done[m_owner]) rel = 1'b1;
         else if (!req[m_owner]) rel = 1'b1;
         else if (m_hold == MAX_HOLD) begin
            rel  = 1'b1;
            m_to = 1'b1;
         end
         if (rel) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_hold  = 0;
         end else begin
            m_hold++;
         end
      end
   endtask

   // Drive inputs on the falling edge, let the DUT and model take the rising
   // edge, return 1 ns later for sampling.
   task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
      @(negedge clk);
      req  = r;
      done = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b1111;
      done  = '0;
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 12'h000) begin
         failures++;
         $display("FAIL reset_held: got %h want %h", obs, 12'h000);
      end
      @(negedge clk);
      req   = '0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs !== model_vec()) begin
         failures++;
         $display("FAIL reset_release: got %h want %h", obs, model_vec());
      end
   endtask

   task automatic test_single();
      step(4'b0010, 4'b0000);
      checks++;
      if (grant !== 4'b0010 || sel !== 6'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_grant: got g=%b s=%0d b=%b want g=0010 s=1 b=1",
                  grant, sel, busy);
      end
      step(4'b0010, 4'b0000);
      step(4'b0010, 4'b0000);
      checks++;
      if (obs !== model_vec()) begin
         failures++;
         $display("FAIL single_hold: got %h want %h", obs, model_vec());
      end
      step(4'b0010, 4'b0010);
      checks++;
      if (grant !== 4'b0000 || sel !== 6'd1 || busy !== 1'b0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL single_release: got g=%b s=%0d b=%b t=%b want g=0000 s=1 b=0 t=0",
                  grant, sel, busy, timeout);
      end
      step(4'b0000, 4'b0000);
      checks++;
      if (obs !== model_vec()) begin
         failures++;
         $display("FAIL single_idle: got %h want %h", obs, model_vec());
      end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] d;
      logic [NREQ-1:0] exp_g;
      reset_dut();
      for (int k = 0; k < 15; k++) begin
         d = '0;
         if (k % 3 == 2) d[(k / 3) % 4] = 1'b1;
         step(4'b1111, d);
         exp_g = '0;
         exp_g[(k / 3) % 4] = (k % 3 != 2);
         checks++;
         if (grant !== exp_g) begin
            failures++;
            $display("FAIL rr_order k=%0d: got %b want %b", k, grant, exp_g);
         end
         checks++;
         if (obs !== model_vec()) begin
            failures++;
            $display("FAIL rr_model k=%0d: got %h want %h", k, obs, model_vec());
         end
      end
   endtask

   task automatic test_timeout();
      logic [NREQ-1:0] exp_g;
      logic            exp_t;
      reset_dut();
      for (int c = 1; c <= 12; c++) begin
         step(4'b0100, 4'b0000);
         exp_g = (((c - 1) % 5) < 4) ? 4'b0100 : 4'b0000;
         exp_t = (((c - 1) % 5) == 4);
         checks++;
         if (grant !== exp_g || timeout !== exp_t) begin
            failures++;
            $display("FAIL timeout c=%0d: got g=%b t=%b want g=%b t=%b",
                     c, grant, timeout, exp_g, exp_t);
         end
         checks++;
         if (obs !== model_vec()) begin
            failures++;
            $display("FAIL timeout_model c=%0d: got %h want %h", c, obs, model_vec());
         end
      end
   endtask

   task automatic test_withdraw_tie();
      reset_dut();
      step(4'b1000, 4'b0000);
      step(4'b1000, 4'b0000);
      step(4'b0000, 4'b0000);
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0 || sel !== 6'd3) begin
         failures++;
         $display("FAIL withdraw: got g=%b t=%b s=%0d want g=0000 t=0 s=3",
                  grant, timeout, sel);
      end
      for (int c = 0; c < 4; c++) step(4'b0001, 4'b0000);
      checks++;
      if (grant !== 4'b0001) begin
         failures++;
         $display("FAIL tie_held: got %b want 0001", grant);
      end
      step(4'b0001, 4'b0001);
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL tie_release: got g=%b t=%b want g=0000 t=0", grant, timeout);
      end
      checks++;
      if (obs !== model_vec()) begin
         failures++;
         $display("FAIL tie_model: got %h want %h", obs, model_vec());
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      step(4'b1000, 4'b0000);
      checks++;
      if (grant !== 4'b1000) begin
         failures++;
         $display("FAIL areset_pre: got %b want 1000", grant);
      end
      #2;
      rst_n = 1'b0;
      req   = '0;
      #1;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 6'd0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL areset_now: got g=%b b=%b s=%0d t=%b want all zero",
                  grant, busy, sel, timeout);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1001, 4'b0000);
      checks++;
      if (grant !== 4'b0001 || sel !== 6'd0) begin
         failures++;
         $display("FAIL areset_ptr: got g=%b s=%0d want g=0001 s=0", grant, sel);
      end
   endtask

   task automatic test_nonowner_done();
      logic [NREQ-1:0] exp_g;
      reset_dut();
      step(4'b0000, 4'b0001);
      checks++;
      if (obs !== 12'h000) begin
         failures++;
         $display("FAIL idle_done: got %h want %h", obs, 12'h000);
      end
      for (int c = 1; c <= 5; c++) begin
         step(4'b0001, (c == 2) ? 4'b0100 : 4'b0000);
         exp_g = (c < 5) ? 4'b0001 : 4'b0000;
         checks++;
         if (grant !== exp_g || timeout !== (c == 5)) begin
            failures++;
            $display("FAIL nonowner_done c=%0d: got g=%b t=%b want g=%b t=%b",
                     c, grant, timeout, exp_g, (c == 5));
         end
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] cur;
      logic [NREQ-1:0] d;
      int              idx;
      reset_dut();
      cur = '0;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < NREQ; b++) begin
            if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
         end
         d = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
         step(cur, d);
         checks++;
         if (obs !== model_vec()) begin
            failures++;
            $display("FAIL random_model n=%0d: got %h want %h", n, obs, model_vec());
         end
         idx = -1;
         for (int b = 0; b < NREQ; b++) if (grant[b]) idx = b;
         checks++;
         if ((grant & (grant - 1'b1)) !== '0 || busy !== (|grant) ||
             (busy && int'(sel) != idx)) begin
            failures++;
            $display("FAIL random_invariant n=%0d: got g=%b b=%b s=%0d", n, grant, busy, sel);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_withdraw_tie();
      test_async_reset();
      test_nonowner_done();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
